hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage MIPS core. Drives
//  stall/flush enables of IF, IF_ID, ID_EX and EX_MEM regs and forward selects.
//  Covers load-use, branch-compare and mul/div hazards. Owns a multi-cycle
//  mul/div sequencer that freezes the front end while the iterative unit runs.
// PARAMETERS
//  MD_LATENCY  32  cycles the mul/div unit occupies EX (legal range 2..255)
//  CNT_W        8  width of the mul/div countdown counter
// PORTS
//  clk            in   1  core clock, all state on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  RsD, RtD       in   5  source regs of instr in ID
//  RsE, RtE       in   5  source regs of instr in EX
//  WriteRegE/M/W  in   5  destination reg in EX / MEM / WB
//  RegWriteE/M/W  in   1  destination write enable in EX / MEM / WB
//  MemtoRegE/M    in   1  instr in EX / MEM is a load
//  BranchD        in   1  instr in ID is a branch (compared in ID)
//  PCSrcD         in   1  branch taken, resolved in ID
//  MulDivStartE   in   1  mul/div instr entered EX this cycle
//  StallF,StallD  out  1  hold PC / hold IF_ID
//  StallE         out  1  hold ID_EX
//  FlushD,FlushE  out  1  zero IF_ID / ID_EX next edge
//  FlushM         out  1  insert bubble into EX_MEM
//  ForwardAD/BD   out  1  ID comparator operand from MEM ALUOut
//  ForwardAE/BE   out  2  EX operand: 00 regfile, 10 MEM ALUOut, 01 WB Result
//  MulDivBusy     out  1  sequencer in BUSY
//  MulDivDoneE    out  1  one-cycle pulse: result valid in EX this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0; every output forced 0 while low.
//  Forward EX: ForwardAE=10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE;
//   else 01 if same test on W; else 00. MEM wins on tie. BE identical w/ RtE.
//  Forward ID: ForwardAD = RegWriteM & RsD!=0 & RsD==WriteRegM; BD with RtD.
//  lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
//  brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) |
//            (MemtoRegM & WriteRegM in {RsD,RtD})); reg 0 never matches.
//  hzstall = lwstall | brstall -> StallF=StallD=FlushE=1, no other effect.
//  FlushD = PCSrcD & ~StallD (stall has priority; branch retried next cycle).
//  FSM states IDLE, BUSY (2-bit encoding, registered):
//   IDLE: MulDivStartE -> BUSY, cnt<=MD_LATENCY-1.
//   BUSY: cnt<=cnt-1; at cnt==1 -> IDLE next edge. MulDivBusy=1.
//    StallF=StallD=StallE=1, FlushM=1; FlushD/FlushE forced 0 (PCSrcD ignored).
//   MulDivDoneE=1 in the first IDLE cycle after BUSY (registered pulse).
//   Total front-end freeze = MD_LATENCY-1 cycles after start cycle.
//  MulDivStartE while BUSY ignored (cannot legally occur; EX is held).
//  MulDivStartE and hzstall same cycle: both honoured (FlushE from hzstall).
//  Reset mid-BUSY: immediate IDLE, cnt=0, no Done pulse.
//  cnt never wraps: decrement only in BUSY, exits before 0.
//  All stall/flush/forward outputs combinational from inputs + state; no
//  combinational path from outputs back to inputs.
// STRUCTURE
//  Shared package hazard_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10,
//   state encodings MD_IDLE/MD_BUSY, REG_ZERO=5'd0.
//  One sub-module: muldiv_seq (FSM + counter; outputs busy, done).
//  Forward/stall logic stays flat in hazard_ctrl.
// TESTING
//  1 lw $2 in EX (MemtoRegE=1,RtE=2), RsD=2 -> StallF=StallD=FlushE=1, 1 cycle.
//  2 WriteRegM=5,RegWriteM, WriteRegW=5,RegWriteW, RsE=5 -> ForwardAE=10;
//    WriteRegM=0 same case -> 01; RsE=0 -> 00.
//  3 BranchD,RegWriteE,WriteRegE=RtD=7 -> brstall 1 cycle; then PCSrcD=1 ->
//    FlushD=1, StallD=0.
//  4 MD_LATENCY=4, MulDivStartE pulse -> MulDivBusy 3 cycles, stalls+FlushM
//    3 cycles, MulDivDoneE 1 cycle after; PCSrcD in BUSY -> FlushD=0.
//  5 rst_n low 2nd BUSY cycle -> outputs 0 async, IDLE after release, no Done.
//  6 random ISA stream vs. golden reference model: no RAW mismatch over 10k instr.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and its mul/div sequencer.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01
    } md_state_t;

    // EX operand select: MEM stage result wins over WB when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wreg_m,
                                           input logic       wen_m,
                                           input logic [4:0] wreg_w,
                                           input logic       wen_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (wen_m && (wreg_m != REG_ZERO) && (wreg_m == src))
            sel = FWD_MEM;
        else if (wen_w && (wreg_w != REG_ZERO) && (wreg_w == src))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Mul/div sequencer: holds BUSY for MD_LATENCY-1 cycles after the start
// cycle, then emits a registered one-cycle done pulse in the first IDLE cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  MD_IDLE | unit free; a start loads the countdown
//  MD_BUSY | iterative unit running; counts down to 1
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State, countdown and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state: a start while BUSY is ignored; the count leaves BUSY at 1,
    // so it never decrements past zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy = (state_q == MD_BUSY);
        done = done_q;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: forwarding selects,
// load-use / branch-compare stalls, branch flush, and mul/div front-end freeze.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MulDivStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MulDivBusy,
    output logic       MulDivDoneE
);

    logic md_busy;
    logic md_done;
    logic lwstall;
    logic brstall;
    logic hzstall;
    logic brdep_e;
    logic brdep_m;

    muldiv_seq #(
        .MD_LATENCY(MD_LATENCY),
        .CNT_W     (CNT_W)
    ) u_muldiv_seq (
        .clk  (clk),
        .rst_n(rst_n),
        .start(MulDivStartE),
        .busy (md_busy),
        .done (md_done)
    );

    // Stall detection; register 0 is never a real dependency for branches.
    always_comb begin
        lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        brdep_e = RegWriteE && (WriteRegE != REG_ZERO) &&
                  ((WriteRegE == RsD) || (WriteRegE == RtD));
        brdep_m = MemtoRegM && (WriteRegM != REG_ZERO) &&
                  ((WriteRegM == RsD) || (WriteRegM == RtD));
        brstall = BranchD && (brdep_e || brdep_m);
        hzstall = lwstall || brstall;
    end

    // Output decode; everything is held at zero while reset is asserted.
    // A running mul/div freezes IF/ID/EX and suppresses branch/ID_EX flushes.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        ForwardAD   = 1'b0;
        ForwardBD   = 1'b0;
        ForwardAE   = FWD_RF;
        ForwardBE   = FWD_RF;
        MulDivBusy  = 1'b0;
        MulDivDoneE = 1'b0;
        if (rst_n) begin
            ForwardAE   = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
            ForwardBE   = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
            ForwardAD   = RegWriteM && (RsD != REG_ZERO) && (RsD == WriteRegM);
            ForwardBD   = RegWriteM && (RtD != REG_ZERO) && (RtD == WriteRegM);
            StallF      = hzstall || md_busy;
            StallD      = hzstall || md_busy;
            StallE      = md_busy;
            FlushM      = md_busy;
            FlushE      = hzstall && !md_busy;
            FlushD      = PCSrcD && !(hzstall || md_busy);
            MulDivBusy  = md_busy;
            MulDivDoneE = md_done;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with a short mul/div latency.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, MulDivStartE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MulDivBusy, MulDivDoneE;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] sb_q[$];
    logic [15:0] outv;

    // reference model state for the mul/div sequencing
    logic       m_busy;
    logic [7:0] m_left;
    logic       m_done;

    hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MulDivStartE(MulDivStartE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulDivBusy(MulDivBusy), .MulDivDoneE(MulDivDoneE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outv = {2'b00, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                   ForwardAD, ForwardBD, ForwardAE, ForwardBE,
                   MulDivBusy, MulDivDoneE};

    // sequencer reference: busy for MD_LAT-1 cycles after start, then done pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 8'd0;
            m_done <= 1'b0;
        end else begin
            m_done <= m_busy && (m_left == 8'd1);
            if (!m_busy) begin
                if (MulDivStartE) begin
                    m_busy <= 1'b1;
                    m_left <= 8'(MD_LAT - 1);
                end
            end else begin
                m_left <= m_left - 8'd1;
                if (m_left == 8'd1) m_busy <= 1'b0;
            end
        end
    end

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src) return 2'b10;
        if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:0] model();
        logic lw, br, hz, sf, fd, fe, fad, fbd;
        if (!rst_n) return 16'h0000;
        lw  = MemtoRegE && (RtE == RsD || RtE == RtD);
        br  = BranchD &&
              ((RegWriteE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
               (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
        hz  = lw || br;
        sf  = hz || m_busy;
        fd  = PCSrcD && !sf;
        fe  = hz && !m_busy;
        fad = RegWriteM && RsD != 5'd0 && RsD == WriteRegM;
        fbd = RegWriteM && RtD != 5'd0 && RtD == WriteRegM;
        return {2'b00, sf, sf, m_busy, fd, fe, m_busy, fad, fbd,
                ref_fwd(RsE), ref_fwd(RtE), m_busy, m_done};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // push the expectation for the driven inputs, compare once settled, advance
    task automatic step(input string tag);
        #1;
        sb_q.push_back(model());
        #1;
        check(tag, outv, sb_q.pop_front());
        @(negedge clk);
    endtask

    task automatic clr();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, PCSrcD, MulDivStartE} = '0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        @(negedge clk);
        PCSrcD = 1'b1;
        #1 check("reset_outs", outv, 16'h0000);
        step("reset");
        rst_n = 1'b1;
        clr();
        step("idle");

        // load-use
        MemtoRegE = 1'b1; RtE = 5'd2; RsD = 5'd2;
        #1 check("lw_stallF", 16'(StallF), 16'd1);
        check("lw_flushE", 16'(FlushE), 16'd1);
        step("lw");
        clr();
        #1 check("lw_gone", 16'(StallF), 16'd0);
        step("lw_after");

        // EX forwarding priority
        RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
        RsE = 5'd5; RtE = 5'd5;
        #1 check("fwdAE_mem", 16'(ForwardAE), 16'b10);
        check("fwdBE_mem", 16'(ForwardBE), 16'b10);
        step("fwd_mem");
        WriteRegM = 5'd0;
        #1 check("fwdAE_wb", 16'(ForwardAE), 16'b01);
        step("fwd_wb");
        RsE = 5'd0;
        #1 check("fwdAE_rf", 16'(ForwardAE), 16'b00);
        step("fwd_rf");
        clr();
        RegWriteM = 1'b1; WriteRegM = 5'd9; RsD = 5'd9; RtD = 5'd3;
        #1 check("fwdAD", 16'({ForwardAD, ForwardBD}), 16'b10);
        step("fwd_id");
        clr();

        // branch compare stall then taken branch
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7; RtD = 5'd7;
        #1 check("br_stallD", 16'(StallD), 16'd1);
        check("br_flushE", 16'(FlushE), 16'd1);
        step("brstall");
        RegWriteE = 1'b0; PCSrcD = 1'b1;
        #1 check("br_flushD", 16'({FlushD, StallD}), 16'b10);
        step("br_taken");
        clr();
        BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0;
        #1 check("br_reg0", 16'(StallD), 16'd0);
        step("br_reg0");
        clr();

        // mul/div sequence with hazard in the start cycle
        MulDivStartE = 1'b1; MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd4;
        #1 check("md_start_busy", 16'(MulDivBusy), 16'd0);
        check("md_start_flushE", 16'(FlushE), 16'd1);
        step("md_start");
        clr();
        PCSrcD = 1'b1;
        for (int i = 0; i < MD_LAT - 1; i++) begin
            #1 check("md_busy", 16'({MulDivBusy, StallF, StallD, StallE, FlushM, FlushD, FlushE}),
                     16'b1111100);
            step("md_busy_sb");
        end
        #1 check("md_done", 16'({MulDivDoneE, MulDivBusy, FlushD}), 16'b101);
        step("md_done_sb");
        #1 check("md_done_once", 16'(MulDivDoneE), 16'd0);
        step("md_after");
        clr();

        // reset during second busy cycle
        MulDivStartE = 1'b1;
        step("rst_start");
        MulDivStartE = 1'b0; PCSrcD = 1'b1; MemtoRegE = 1'b1; RegWriteM = 1'b1;
        WriteRegM = 5'd1; RsE = 5'd1;
        step("rst_busy1");
        #1 rst_n = 1'b0;
        #1 check("rst_mid_busy", outv, 16'h0000);
        step("rst_low");
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < MD_LAT + 1; i++) begin
            #1 check("rst_no_done", 16'({MulDivDoneE, MulDivBusy}), 16'b00);
            step("rst_after");
        end

        // random instruction stream
        for (int i = 0; i < 10000; i++) begin
            RsD = 5'($urandom_range(0, 7));       RtD = 5'($urandom_range(0, 7));
            RsE = 5'($urandom_range(0, 7));       RtE = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7)); WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemtoRegM = ($urandom_range(0, 3) == 0);
            BranchD   = ($urandom_range(0, 3) == 0);
            PCSrcD    = ($urandom_range(0, 3) == 0);
            MulDivStartE = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
